// File: rtl/mousetrap_sync_sink.sv
// mousetrap_sync_sink
//   Clocked terminating receiver for a 2-phase bundled-data MOUSETRAP pipeline.
//   Sits after the last mousetrap_elt stage: synchronises the transition-
//   signalled request, captures the bundled data word into a small FIFO,
//   returns a transition-signalled ack and presents the words as a
//   valid/ready stream to clocked logic.
//
// Parameters
//   WIDTH        data word width
//   SYNC_STAGES  flops in the req synchroniser (>=2)
//   DEPTH        FIFO entries (power of 2, >=2)
//
// Ports
//   clk         system clock, all state on rising edge
//   rstn        synchronous reset, active-low
//   reqN        2-phase request from the last stage (its doneN)
//   datain      bundled data, stable while reqN != ackN
//   ackN        2-phase ack back to the last stage
//   dout        FIFO head word (combinational read)
//   dout_valid  dout holds a valid word
//   dout_ready  consumer accepts dout this cycle
//   level       current FIFO occupancy
module mousetrap_sync_sink #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       reqN,
  input  logic [WIDTH-1:0]           datain,
  output logic                       ackN,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [SYNC_STAGES-1:0]      sync_pipe;
  logic                        req_s;
  logic                        ack_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [LW-1:0]               lvl_q;
  logic                        pend;
  logic                        push;
  logic                        pop;

  // reqN is asynchronous to clk; only its synchronised copy is used.
  // datain is not synchronised: by the time req_s shows the transition,
  // the bundled data has long been stable.
  always_ff @(posedge clk) begin
    if (!rstn) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], reqN};
  end

  assign req_s = sync_pipe[SYNC_STAGES-1];

  always_comb begin
    pend = (req_s != ack_q);
    pop  = dout_valid && dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = pend && ((lvl_q < LVL_FULL) || pop);
  end

  // ack_q is the only phase state: toggling it on push clears pend in the
  // same edge, so each token is pushed exactly once.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
      mem    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= datain;
        wr_ptr      <= wr_ptr + PTR_ONE;
        ack_q       <= ~ack_q;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + LVL_ONE;
        2'b01:   lvl_q <= lvl_q - LVL_ONE;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  assign ackN       = ack_q;
  assign level      = lvl_q;
  assign dout_valid = (lvl_q != '0);
  assign dout       = mem[rd_ptr];

endmodule
